// File: rtl/frame_streamer.sv
// frame_streamer: reads a finished frame out of the synchronous result RAM in
// raster order, quantizes each signed result (arithmetic shift + saturate),
// tags sof/eol/eof and streams pixels downstream through a 2-entry skid buffer.
//
// Stream handshake: a pixel transfers in any cycle where m_valid && m_ready.
// m_valid is registered and never looks at m_ready; once m_valid is high the
// pixel and its tags hold steady until that transfer happens.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DRAIN.
module frame_streamer #(
  parameter int AddressBitWidth = 17,
  parameter int DataBitWidth    = 12,
  parameter int Rows            = 50,
  parameter int Cols            = 50,
  parameter int OutBitWidth     = 8,
  parameter int Shift           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AddressBitWidth-1:0] base_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [AddressBitWidth-1:0] mem_rd_addr,
  input  logic [DataBitWidth-1:0]    mem_rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OutBitWidth-1:0]     m_data,
  output logic                       m_sof,
  output logic                       m_eol,
  output logic                       m_eof,
  output logic [1:0]                 dbg_state
);

  localparam int Total = Rows * Cols;
  localparam int IdxW  = $clog2(Total + 1);
  localparam int RowW  = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int ColW  = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int QMax  = (2 ** (OutBitWidth - 1)) - 1;
  localparam int QMin  = -(2 ** (OutBitWidth - 1));
  // Buffer entry layout: {sof, eol, eof, pixel}
  localparam int EntW  = OutBitWidth + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AddressBitWidth-1:0] base_q;
  logic [IdxW-1:0]            rd_idx_q;
  logic [RowW-1:0]            row_q;
  logic [ColW-1:0]            col_q;
  logic                       pend_q;
  logic                       pend_sof_q, pend_eol_q, pend_eof_q;
  logic [1:0]                 occ_q;
  logic [EntW-1:0]            head_q, tail_q;
  logic                       done_q;

  logic                       accept;
  logic                       pop;
  logic                       room;
  logic                       head_eof;
  logic signed [DataBitWidth-1:0] q_shift;
  logic signed [31:0]         q_ext;
  logic [OutBitWidth-1:0]     q_out;
  logic [EntW-1:0]            new_entry;

  assign m_valid  = (occ_q != 2'd0);
  assign pop      = m_valid & m_ready;
  assign head_eof = head_q[OutBitWidth];
  // Room for one more read: whatever is buffered plus the word in flight,
  // minus what leaves this cycle, must stay below the buffer depth.
  assign room     = ({1'b0, occ_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});

  // FSM next state and read strobe
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if ((rd_idx_q < IdxW'(Total)) && room) mem_rd_en = 1'b1;
        if (mem_rd_en && (rd_idx_q == IdxW'(Total - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_addr = mem_rd_en ? (base_q + AddressBitWidth'(rd_idx_q)) : '0;

  // Quantize the returning word: floor shift, then clamp to the output range
  assign q_shift = $signed(mem_rd_data) >>> Shift;
  assign q_ext   = {{(32 - DataBitWidth){q_shift[DataBitWidth-1]}}, q_shift};

  always_comb begin
    q_out = q_ext[OutBitWidth-1:0];
    if (q_ext > QMax)      q_out = OutBitWidth'(QMax);
    else if (q_ext < QMin) q_out = OutBitWidth'(QMin);
  end

  assign new_entry = {pend_sof_q, pend_eol_q, pend_eof_q, q_out};

  // State register and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && pop && head_eof;
    end
  end

  // Read side: raster position, tags of the word in flight, pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      rd_idx_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pend_q     <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eol_q <= 1'b0;
      pend_eof_q <= 1'b0;
    end else if (accept) begin
      base_q   <= base_addr;
      rd_idx_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      pend_q <= mem_rd_en;
      if (mem_rd_en) begin
        rd_idx_q   <= rd_idx_q + IdxW'(1);
        pend_sof_q <= (row_q == '0) && (col_q == '0);
        pend_eol_q <= (col_q == ColW'(Cols - 1));
        pend_eof_q <= (row_q == RowW'(Rows - 1)) && (col_q == ColW'(Cols - 1));
        if (col_q == ColW'(Cols - 1)) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end
    end
  end

  // Two-entry skid buffer: head drives the stream, tail catches overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (accept) begin
      occ_q <= 2'd0;
    end else begin
      case ({pend_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= new_entry;
          else               tail_q <= new_entry;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= new_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_data    = head_q[OutBitWidth-1:0];
  assign m_eof     = m_valid & head_q[OutBitWidth];
  assign m_eol     = m_valid & head_q[OutBitWidth+1];
  assign m_sof     = m_valid & head_q[OutBitWidth+2];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
